// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader and the simple_cpu instruction RAM:
// loader state encoding, error codes, frame marker and RAM depth.
package cpu_pkg;

    localparam int         IMEM_DEPTH = 16;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CSUM    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } loader_err_e;

    // A frame length is usable when it names at least one word and fits the RAM.
    function automatic logic len_ok(input logic [7:0] len, input int depth);
        return (len != 8'd0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/loader_watchdog.sv
// Inter-byte idle counter for the program loader. Counts idle cycles while
// enabled, clears on every accepted byte, and flags expiry on the cycle whose
// edge would complete TIMEOUT consecutive idle cycles. TIMEOUT=0 disables it.
module loader_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: held at zero when inactive or on a byte, saturating at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader. Accepts a SYNC/LEN/payload/CSUM frame over a
// valid/ready byte link, writes the payload into the instruction RAM from
// address 0 upward, verifies the checksum and releases simple_cpu from reset
// only after a frame has been loaded and verified.
module program_loader #(
    parameter int         DEPTH     = cpu_pkg::IMEM_DEPTH,
    parameter int         ADDR_W    = $clog2(DEPTH),
    parameter logic [7:0] SYNC_BYTE = cpu_pkg::SYNC_BYTE,
    parameter int         TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    import cpu_pkg::*;

    loader_state_e     state_q, state_d;
    logic              rx_ready_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    loader_err_e       err_q, err_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        sum_q, sum_d;

    logic accept;
    logic wd_enable;
    logic wd_expired;

    assign accept    = rx_valid && rx_ready_q;
    assign wd_enable = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);

    loader_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Frame FSM next-state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        err_d       = err_q;
        words_d     = words_q;
        len_d       = len_q;
        sum_d       = sum_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d     = ST_LEN;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_d       = ERR_NONE;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (len_ok(rx_data, DEPTH)) begin
                        state_d = ST_DATA;
                        len_d   = rx_data[ADDR_W:0];
                        sum_d   = '0;
                        words_d = '0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_LEN;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = words_q[ADDR_W-1:0];
                    wdata_d = rx_data;
                    sum_d   = sum_q + rx_data;
                    words_d = words_q + (ADDR_W+1)'(1);
                    if (words_d == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        state_d     = ST_DONE;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Expiry only fires in LEN/DATA/CSUM on a cycle with no byte, so it
        // never competes with the per-state byte handling above.
        if (wd_expired) begin
            state_d     = ST_ERROR;
            cpu_reset_d = 1'b1;
            error_d     = 1'b1;
            err_d       = ERR_TIMEOUT;
        end
    end

    // State and output registers; reset overrides any byte offered on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rx_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_q       <= ERR_NONE;
            words_q     <= '0;
            len_q       <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_q       <= err_d;
            words_q     <= words_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign err_code     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frame scenarios plus
// randomized frames checked against a frame-level reference model and a
// bench-side instruction RAM fed by the write port.
module tb_program_loader;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    program_loader #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Edge counter: during the cycle following edge k, cyc == k.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction RAM and write log, fed from the write port mid-cycle.
    logic [7:0]        ram [DEPTH];
    int unsigned       wr_cyc_q [$];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [7:0]        wr_data_q [$];
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            ram[imem_addr] = imem_wdata;
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte for exactly one edge; acc returns that edge's number.
    task automatic send(input logic [7:0] b, output int unsigned acc);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        acc      = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if ({rx_ready, imem_we, imem_addr, imem_wdata} !== 14'h0) begin
            n_errors++; $display("FAIL reset_link: got ready=%b we=%b addr=%h wdata=%h want all 0", rx_ready, imem_we, imem_addr, imem_wdata); end
        n_checks++; if (cpu_reset !== 1'b1) begin
            n_errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++; if ({load_done, load_error, err_code} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_status: got done=%b err=%b code=%b want 0 0 00", load_done, load_error, err_code); end
        n_checks++; if (words_loaded !== 5'd0) begin
            n_errors++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        reset = 1'b0;
        tick();
        n_checks++; if (rx_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_release_ready: got %b want 1", rx_ready); end
        n_checks++; if (cpu_reset !== 1'b1) begin
            n_errors++; $display("FAIL reset_release_cpu: got %b want 1", cpu_reset); end
    endtask

    task automatic test_good_frame();
        int unsigned t, k0, k1, k2;
        int base = wr_addr_q.size();
        send(8'hA5, t); send(8'h03, t);
        send(8'hA0, k0); send(8'h21, k1); send(8'hB3, k2);
        n_checks++; if (cpu_reset !== 1'b1) begin
            n_errors++; $display("FAIL good_held_before_csum: got %b want 1", cpu_reset); end
        send(8'h74, t);
        n_checks++; if (wr_addr_q.size() - base !== 3) begin
            n_errors++; $display("FAIL good_write_count: got %0d want 3", wr_addr_q.size() - base); end
        if (wr_addr_q.size() - base == 3) begin
            n_checks++; if ({wr_addr_q[base], wr_addr_q[base+1], wr_addr_q[base+2]} !== 12'h012 ||
                            {wr_data_q[base], wr_data_q[base+1], wr_data_q[base+2]} !== 24'hA021B3) begin
                n_errors++; $display("FAIL good_writes: got addr %h,%h,%h data %h,%h,%h want 0,1,2 A0,21,B3",
                    wr_addr_q[base], wr_addr_q[base+1], wr_addr_q[base+2], wr_data_q[base], wr_data_q[base+1], wr_data_q[base+2]); end
            n_checks++; if (wr_cyc_q[base] !== k0 || wr_cyc_q[base+1] !== k1 || wr_cyc_q[base+2] !== k2) begin
                n_errors++; $display("FAIL good_write_timing: got cycles %0d,%0d,%0d want %0d,%0d,%0d",
                    wr_cyc_q[base], wr_cyc_q[base+1], wr_cyc_q[base+2], k0, k1, k2); end
        end
        n_checks++; if ({cpu_reset, load_done, load_error, err_code} !== 5'b01000) begin
            n_errors++; $display("FAIL good_status: got rst=%b done=%b err=%b code=%b want 0 1 0 00", cpu_reset, load_done, load_error, err_code); end
        n_checks++; if (words_loaded !== 5'd3) begin
            n_errors++; $display("FAIL good_words: got %0d want 3", words_loaded); end
        n_checks++; if (imem_we !== 1'b0) begin
            n_errors++; $display("FAIL good_no_write_after_csum: got we=%b want 0", imem_we); end
    endtask

    task automatic test_resync_after_done();
        int unsigned t;
        int base;
        send(8'h5A, t);
        n_checks++; if ({cpu_reset, load_done} !== 2'b01) begin
            n_errors++; $display("FAIL resync_ignore: got rst=%b done=%b want 0 1", cpu_reset, load_done); end
        send(8'hA5, t);
        n_checks++; if ({cpu_reset, load_done, load_error} !== 3'b100) begin
            n_errors++; $display("FAIL resync_sync: got rst=%b done=%b err=%b want 1 0 0", cpu_reset, load_done, load_error); end
        base = wr_addr_q.size();
        send(8'h03, t); send(8'hA5, t); send(8'hA5, t); send(8'h07, t);
        send(8'h51, t);
        n_checks++; if (wr_addr_q.size() - base !== 3 ||
                        {ram[0], ram[1], ram[2]} !== 24'hA5A507) begin
            n_errors++; $display("FAIL resync_sync_as_data: got %0d writes ram %h %h %h want 3 writes A5 A5 07",
                wr_addr_q.size() - base, ram[0], ram[1], ram[2]); end
        n_checks++; if ({cpu_reset, load_done, load_error} !== 3'b010) begin
            n_errors++; $display("FAIL resync_done: got rst=%b done=%b err=%b want 0 1 0", cpu_reset, load_done, load_error); end
    endtask

    task automatic test_bad_csum();
        int unsigned t;
        int base = wr_addr_q.size();
        send(8'hA5, t); send(8'h02, t); send(8'h11, t); send(8'h22, t);
        send(8'h00, t);
        n_checks++; if ({cpu_reset, load_done, load_error, err_code} !== 5'b10110) begin
            n_errors++; $display("FAIL csum_status: got rst=%b done=%b err=%b code=%b want 1 0 1 10", cpu_reset, load_done, load_error, err_code); end
        n_checks++; if (wr_addr_q.size() - base !== 2) begin
            n_errors++; $display("FAIL csum_writes: got %0d want 2", wr_addr_q.size() - base); end
        n_checks++; if (words_loaded !== 5'd2) begin
            n_errors++; $display("FAIL csum_words: got %0d want 2", words_loaded); end
    endtask

    task automatic test_bad_len();
        int unsigned t;
        logic [7:0] lens [2];
        int base = wr_addr_q.size();
        lens[0] = 8'h00;
        lens[1] = 8'h11;
        for (int i = 0; i < 2; i++) begin
            send(8'hA5, t);
            n_checks++; if ({load_error, err_code} !== 3'b000) begin
                n_errors++; $display("FAIL len_sync_clears[%0d]: got err=%b code=%b want 0 00", i, load_error, err_code); end
            send(lens[i], t);
            tick();
            n_checks++; if ({cpu_reset, load_done, load_error, err_code} !== 5'b10101) begin
                n_errors++; $display("FAIL len_status[%0d]: got rst=%b done=%b err=%b code=%b want 1 0 1 01", i, cpu_reset, load_done, load_error, err_code); end
        end
        n_checks++; if (wr_addr_q.size() - base !== 0) begin
            n_errors++; $display("FAIL len_writes: got %0d want 0", wr_addr_q.size() - base); end
    endtask

    task automatic test_reset_mid_frame();
        int unsigned t;
        int base = wr_addr_q.size();
        send(8'hA5, t); send(8'h03, t); send(8'h11, t);
        rx_valid = 1'b1; rx_data = 8'h22; reset = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        n_checks++; if ({imem_we, imem_addr, imem_wdata, rx_ready} !== 14'h0) begin
            n_errors++; $display("FAIL midreset_link: got we=%b addr=%h wdata=%h ready=%b want all 0", imem_we, imem_addr, imem_wdata, rx_ready); end
        n_checks++; if ({cpu_reset, load_done, load_error, err_code, words_loaded} !== {5'b10000, 5'd0}) begin
            n_errors++; $display("FAIL midreset_status: got rst=%b done=%b err=%b code=%b words=%0d want 1 0 0 00 0",
                cpu_reset, load_done, load_error, err_code, words_loaded); end
        tick();
        n_checks++; if (wr_addr_q.size() - base !== 1) begin
            n_errors++; $display("FAIL midreset_writes: got %0d want 1", wr_addr_q.size() - base); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int unsigned t;
        int base = wr_addr_q.size();
        send(8'hA5, t); send(8'h04, t); send(8'h05, t);
        repeat (TIMEOUT - 1) tick();
        n_checks++; if ({load_error, err_code} !== 3'b000) begin
            n_errors++; $display("FAIL timeout_early: got err=%b code=%b want 0 00", load_error, err_code); end
        tick();
        n_checks++; if ({cpu_reset, load_done, load_error, err_code} !== 5'b10111) begin
            n_errors++; $display("FAIL timeout_status: got rst=%b done=%b err=%b code=%b want 1 0 1 11", cpu_reset, load_done, load_error, err_code); end
        repeat (20) tick();
        n_checks++; if (wr_addr_q.size() - base !== 1) begin
            n_errors++; $display("FAIL timeout_writes: got %0d want 1", wr_addr_q.size() - base); end
    endtask

    // Random frames: garbage between frames, random gaps, bad LEN / bad CSUM mix.
    task automatic test_random(input int n_frames);
        logic [7:0] exp_ram [DEPTH];
        logic [7:0] pl [DEPTH];
        logic [7:0] b, sum, len_b;
        logic       exp_rst, exp_done, exp_err;
        logic [1:0] exp_code;
        int         kind, len, base, bad_seq, bad_ram;
        int unsigned t;
        exp_rst = 1'b1; exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'b00;
        for (int f = 0; f < n_frames; f++) begin
            if (f > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h5A;
                    send(b, t);
                end
                n_checks++; if ({cpu_reset, load_done, load_error, err_code} !== {exp_rst, exp_done, exp_err, exp_code}) begin
                    n_errors++; $display("FAIL rnd_idle_hold[%0d]: got %b%b%b%b want %b%b%b%b", f,
                        cpu_reset, load_done, load_error, err_code, exp_rst, exp_done, exp_err, exp_code); end
            end
            kind = (f == 0) ? 9 : int'($urandom_range(0, 9));
            base = wr_addr_q.size();
            send(8'hA5, t);
            repeat ($urandom_range(0, 2)) tick();
            if (kind == 0) begin
                len_b = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255));
                send(len_b, t);
                len = 0;
                exp_rst = 1'b1; exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'b01;
            end else begin
                len = (f == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
                sum = 8'h00;
                for (int i = 0; i < len; i++) begin
                    pl[i] = 8'($urandom);
                    sum   = sum + pl[i];
                end
                send(8'(len), t);
                for (int i = 0; i < len; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(pl[i], t);
                end
                repeat ($urandom_range(0, 2)) tick();
                if (kind <= 3) begin
                    send(sum ^ 8'($urandom_range(1, 255)), t);
                    exp_rst = 1'b1; exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'b10;
                end else begin
                    send(sum, t);
                    exp_rst = 1'b0; exp_done = 1'b1; exp_err = 1'b0; exp_code = 2'b00;
                end
                for (int i = 0; i < len; i++) exp_ram[i] = pl[i];
                n_checks++; if (words_loaded !== 5'(len)) begin
                    n_errors++; $display("FAIL rnd_words[%0d]: got %0d want %0d", f, words_loaded, len); end
            end
            n_checks++; if ({cpu_reset, load_done, load_error, err_code} !== {exp_rst, exp_done, exp_err, exp_code}) begin
                n_errors++; $display("FAIL rnd_status[%0d]: got %b%b%b%b want %b%b%b%b", f,
                    cpu_reset, load_done, load_error, err_code, exp_rst, exp_done, exp_err, exp_code); end
            n_checks++; if (wr_addr_q.size() - base !== len) begin
                n_errors++; $display("FAIL rnd_write_count[%0d]: got %0d want %0d", f, wr_addr_q.size() - base, len); end
            if (wr_addr_q.size() - base == len) begin
                bad_seq = 0;
                for (int i = 0; i < len; i++)
                    if (wr_addr_q[base+i] !== 4'(i) || wr_data_q[base+i] !== pl[i]) bad_seq++;
                n_checks++; if (bad_seq !== 0) begin
                    n_errors++; $display("FAIL rnd_write_order[%0d]: got %0d out-of-order writes want 0", f, bad_seq); end
            end
            bad_ram = 0;
            for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_ram[i]) bad_ram++;
            n_checks++; if (bad_ram !== 0) begin
                n_errors++; $display("FAIL rnd_ram[%0d]: got %0d differing words want 0", f, bad_ram); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_resync_after_done();
        test_bad_csum();
        test_bad_len();
        test_reset_mid_frame();
        test_timeout();
        test_random(40);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no completion want completion");
        $fatal(1, "time limit");
    end

endmodule
